// File: rtl/wb_pipe_stage.sv
// rtl/wb_pipe_stage.sv - registered writeback stage with late-load wait, flush and retire counter
module wb_pipe_stage #(
   parameter int DATA_W = 16,
   parameter int RA_W   = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] pc_inc2,
   input  logic              ex_cond,
   input  logic [4:0]        wb_ctrl,
   input  logic [RA_W-1:0]   dst_reg,
   input  logic              mr_valid,
   input  logic [DATA_W-1:0] mr_data,
   input  logic              flush,
   output logic              reg_write,
   output logic [RA_W-1:0]   out_dst_reg,
   output logic [DATA_W-1:0] rw_data,
   output logic              pend_valid,
   output logic [RA_W-1:0]   pend_reg,
   output logic [CNT_W-1:0]  retire_count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_READY    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_alu;
   logic [DATA_W-1:0]   r_pc;
   logic                r_cond;
   logic [4:0]          r_ctrl;
   logic [RA_W-1:0]     r_dst;
   logic [DATA_W-1:0]   r_mdata;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_capture;
   logic                w_load_done;
   logic [DATA_W-1:0]   w_load_val;
   logic [DATA_W-1:0]   w_wb_val;

   // READY is the retire cycle, so a new instruction may enter behind it
   assign in_ready    = !flush && (r_state == S_IDLE || r_state == S_READY);
   assign w_capture   = in_valid && in_ready;
   assign w_load_done = (r_state == S_WAIT_MEM) && mr_valid && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = S_IDLE;
         S_WAIT_MEM: if (mr_valid) w_next = S_READY;
         S_READY:    w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
      if (w_capture) w_next = (wb_ctrl[1:0] == 2'b11) ? S_WAIT_MEM : S_READY;
      if (flush)     w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu   <= '0;
         r_pc    <= '0;
         r_cond  <= 1'b0;
         r_ctrl  <= '0;
         r_dst   <= '0;
         r_mdata <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_capture) begin
            r_alu  <= alu_out;
            r_pc   <= pc_inc2;
            r_cond <= ex_cond;
            r_ctrl <= wb_ctrl;
            r_dst  <= dst_reg;
         end
         if (w_load_done) r_mdata <= mr_data;
         // a READY instruction retires even under flush, since it is older than the flush
         if (r_state == S_READY) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_load_val = r_mdata;
      if (r_ctrl[3])
         w_load_val = {{(DATA_W-8){r_ctrl[4] & r_mdata[7]}}, r_mdata[7:0]};
   end

   always_comb begin
      case (r_ctrl[1:0])
         2'b00:   w_wb_val = r_alu;
         2'b01:   w_wb_val = r_pc;
         2'b10:   w_wb_val = {{(DATA_W-1){1'b0}}, r_cond};
         default: w_wb_val = w_load_val;
      endcase
   end

   assign reg_write    = (r_state == S_READY) && r_ctrl[2];
   assign out_dst_reg  = r_dst;
   assign rw_data      = w_wb_val;
   assign pend_valid   = (r_state != S_IDLE) && r_ctrl[2];
   assign pend_reg     = r_dst;
   assign retire_count = r_cnt;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb/tb_wb_pipe_stage.sv - self-checking bench for wb_pipe_stage with directed and random stimulus
module tb_wb_pipe_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, ex_cond, mr_valid, flush;
    logic [15:0] alu_out, pc_inc2, mr_data;
    logic [4:0]  wb_ctrl;
    logic [2:0]  dst_reg;
    logic        in_ready, reg_write, pend_valid;
    logic [2:0]  out_dst_reg, pend_reg;
    logic [15:0] rw_data, retire_count;
    logic        in_ready_w, reg_write_w, pend_valid_w;
    logic [2:0]  out_dst_reg_w, pend_reg_w;
    logic [15:0] rw_data_w;
    logic [1:0]  retire_count_w;
    int          errors = 0;
    int          checks = 0;

    always #10 clk = ~clk;

    wb_pipe_stage #(.DATA_W(16), .RA_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_out(alu_out),
        .pc_inc2(pc_inc2), .ex_cond(ex_cond), .wb_ctrl(wb_ctrl), .dst_reg(dst_reg),
        .mr_valid(mr_valid), .mr_data(mr_data), .flush(flush), .reg_write(reg_write),
        .out_dst_reg(out_dst_reg), .rw_data(rw_data), .pend_valid(pend_valid),
        .pend_reg(pend_reg), .retire_count(retire_count));

    wb_pipe_stage #(.DATA_W(16), .RA_W(3), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .alu_out(alu_out),
        .pc_inc2(pc_inc2), .ex_cond(ex_cond), .wb_ctrl(wb_ctrl), .dst_reg(dst_reg),
        .mr_valid(mr_valid), .mr_data(mr_data), .flush(flush), .reg_write(reg_write_w),
        .out_dst_reg(out_dst_reg_w), .rw_data(rw_data_w), .pend_valid(pend_valid_w),
        .pend_reg(pend_reg_w), .retire_count(retire_count_w));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 0; ex_cond = 0; mr_valid = 0; flush = 0;
        alu_out = 0; pc_inc2 = 0; mr_data = 0; wb_ctrl = 0; dst_reg = 0;
    endtask

    task automatic issue(input logic v, input logic [4:0] c, input logic [2:0] d, input logic [15:0] a);
        in_valid = v; wb_ctrl = c; dst_reg = d; alu_out = a;
    endtask

    task automatic do_reset;
        idle_inputs();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    function automatic logic [15:0] load_value(input logic [4:0] c, input logic [15:0] md);
        int b;
        b = int'(md[7:0]);
        if (!c[3]) return md;
        if (c[4] && b >= 128) return 16'(b + 16'hFF00);
        return 16'(b);
    endfunction

    task automatic test_reset;
        do_reset();
        issue(1, 5'b00111, 3'd5, 16'h0);
        tick();
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({reg_write, in_ready, pend_valid, retire_count, rw_data, out_dst_reg} !== {1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {reg_write, in_ready, pend_valid, retire_count, rw_data, out_dst_reg},
                     {1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0});
        end
        #2 rst = 1'b0;
        mr_valid = 1; mr_data = 16'h1234;
        tick();
        mr_valid = 0;
        #1;
        checks++;
        if ({reg_write, pend_valid, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_drops_load: got %b expected 001", {reg_write, pend_valid, in_ready});
        end
        tick();
        checks++;
        if (retire_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", retire_count);
        end
    endtask

    task automatic test_alu_stream;
        logic [15:0] vals [3];
        vals = '{16'h1234, 16'h0042, 16'hFFFF};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) issue(1, 5'b00100, 3'(i + 1), vals[i]);
            else in_valid = 0;
            #1;
            if (i > 0) begin
                checks++;
                if ({reg_write, out_dst_reg, rw_data} !== {1'b1, 3'(i), vals[i-1]}) begin
                    errors++;
                    $display("FAIL alu_stream[%0d]: got %h expected %h", i,
                             {reg_write, out_dst_reg, rw_data}, {1'b1, 3'(i), vals[i-1]});
                end
            end
            if (i < 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL alu_ready[%0d]: got %b expected 1", i, in_ready);
                end
            end
            tick();
        end
        checks++;
        if ({reg_write, retire_count} !== {1'b0, 16'd3}) begin
            errors++;
            $display("FAIL alu_count: got %h expected %h", {reg_write, retire_count}, {1'b0, 16'd3});
        end
    endtask

    task automatic test_src_mux;
        do_reset();
        issue(1, 5'b00101, 3'd1, 16'hAAAA); pc_inc2 = 16'h0102;
        tick();
        issue(1, 5'b00110, 3'd2, 16'hAAAA); ex_cond = 1; pc_inc2 = 16'h7777;
        #1;
        checks++;
        if ({reg_write, rw_data} !== {1'b1, 16'h0102}) begin
            errors++;
            $display("FAIL src_pc: got %h expected %h", {reg_write, rw_data}, {1'b1, 16'h0102});
        end
        tick();
        issue(1, 5'b00000, 3'd3, 16'h5555); ex_cond = 0;
        #1;
        checks++;
        if ({reg_write, rw_data} !== {1'b1, 16'h0001}) begin
            errors++;
            $display("FAIL src_cond: got %h expected %h", {reg_write, rw_data}, {1'b1, 16'h0001});
        end
        tick();
        in_valid = 0;
        #1;
        checks++;
        if (reg_write !== 1'b0) begin
            errors++;
            $display("FAIL src_nowrite: got %b expected 0", reg_write);
        end
        tick();
        checks++;
        if (retire_count !== 16'd3) begin
            errors++;
            $display("FAIL src_count: got %0d expected 3", retire_count);
        end
    endtask

    task automatic test_late_load;
        do_reset();
        issue(1, 5'b00111, 3'd5, 16'h0);
        tick();
        issue(1, 5'b00100, 3'd6, 16'h9999);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({in_ready, pend_valid, pend_reg, reg_write} !== {1'b0, 1'b1, 3'd5, 1'b0}) begin
                errors++;
                $display("FAIL late_wait[%0d]: got %h expected %h", i,
                         {in_ready, pend_valid, pend_reg, reg_write}, {1'b0, 1'b1, 3'd5, 1'b0});
            end
            tick();
        end
        in_valid = 0; mr_valid = 1; mr_data = 16'hBEEF;
        tick();
        mr_valid = 0; mr_data = 16'h0;
        #1;
        checks++;
        if ({reg_write, out_dst_reg, rw_data} !== {1'b1, 3'd5, 16'hBEEF}) begin
            errors++;
            $display("FAIL late_data: got %h expected %h", {reg_write, out_dst_reg, rw_data}, {1'b1, 3'd5, 16'hBEEF});
        end
        tick();
        checks++;
        if ({retire_count, pend_valid} !== {16'd1, 1'b0}) begin
            errors++;
            $display("FAIL late_count: got %h expected %h", {retire_count, pend_valid}, {16'd1, 1'b0});
        end
    endtask

    task automatic test_byte_load;
        logic [4:0]  ctl [3];
        logic [15:0] exp_v [3];
        ctl   = '{5'b11111, 5'b01111, 5'b10111};
        exp_v = '{16'hFF80, 16'h0080, 16'h1280};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(1, ctl[i], 3'(i + 4), 16'h0);
            tick();
            in_valid = 0; mr_valid = 1; mr_data = 16'h1280;
            tick();
            mr_valid = 0;
            #1;
            checks++;
            if ({reg_write, out_dst_reg, rw_data} !== {1'b1, 3'(i + 4), exp_v[i]}) begin
                errors++;
                $display("FAIL byte_load[%0d]: got %h expected %h", i,
                         {reg_write, out_dst_reg, rw_data}, {1'b1, 3'(i + 4), exp_v[i]});
            end
            tick();
        end
    endtask

    task automatic test_flush;
        do_reset();
        issue(1, 5'b00111, 3'd2, 16'h0);
        tick();
        issue(1, 5'b00100, 3'd3, 16'h4444); flush = 1; mr_valid = 1; mr_data = 16'h1111;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 0", in_ready);
        end
        tick();
        in_valid = 0; flush = 0;
        #1;
        checks++;
        if ({pend_valid, reg_write} !== 2'b00) begin
            errors++;
            $display("FAIL flush_wait: got %b expected 00", {pend_valid, reg_write});
        end
        tick();
        mr_valid = 0;
        #1;
        checks++;
        if ({reg_write, retire_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL flush_ignored: got %h expected %h", {reg_write, retire_count}, {1'b0, 16'd0});
        end
        issue(1, 5'b00100, 3'd3, 16'h7777);
        tick();
        in_valid = 0; flush = 1;
        #1;
        checks++;
        if ({reg_write, rw_data} !== {1'b1, 16'h7777}) begin
            errors++;
            $display("FAIL flush_ready_write: got %h expected %h", {reg_write, rw_data}, {1'b1, 16'h7777});
        end
        tick();
        flush = 0;
        #1;
        checks++;
        if ({reg_write, retire_count} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL flush_ready_count: got %h expected %h", {reg_write, retire_count}, {1'b0, 16'd1});
        end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(1, 5'b00100, 3'(i), 16'(i));
            tick();
        end
        in_valid = 0;
        tick();
        checks++;
        if ({retire_count_w, retire_count} !== {2'd1, 16'd5}) begin
            errors++;
            $display("FAIL wrap_count: got %h expected %h", {retire_count_w, retire_count}, {2'd1, 16'd5});
        end
    endtask

    task automatic test_random;
        logic        m_held, m_final, m_we, exp_rdy;
        logic [2:0]  m_dst;
        logic [4:0]  m_ctrl;
        logic [15:0] m_val;
        int          m_cnt;
        do_reset();
        m_held = 0; m_final = 0; m_we = 0; m_dst = 0; m_ctrl = 0; m_val = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            wb_ctrl  = 5'($urandom);
            dst_reg  = 3'($urandom);
            alu_out  = 16'($urandom);
            pc_inc2  = 16'($urandom);
            ex_cond  = 1'($urandom);
            mr_valid = ($urandom_range(0, 2) == 0);
            mr_data  = 16'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            exp_rdy = !flush && (!m_held || m_final);
            checks++;
            if ({in_ready, reg_write, pend_valid, retire_count, retire_count_w} !==
                {exp_rdy, m_held && m_final && m_we, m_held && m_we, 16'(m_cnt), 2'(m_cnt % 4)}) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: got %h expected %h", cyc,
                         {in_ready, reg_write, pend_valid, retire_count, retire_count_w},
                         {exp_rdy, m_held && m_final && m_we, m_held && m_we, 16'(m_cnt), 2'(m_cnt % 4)});
            end
            if (m_held && m_final && m_we) begin
                checks++;
                if ({out_dst_reg, rw_data} !== {m_dst, m_val}) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", cyc, {out_dst_reg, rw_data}, {m_dst, m_val});
                end
            end
            if (m_held && m_final) begin
                m_cnt++;
                m_held = 0;
            end else if (m_held && mr_valid && !flush) begin
                m_val = load_value(m_ctrl, mr_data);
                m_final = 1;
            end
            if (flush) m_held = 0;
            if (in_valid && exp_rdy) begin
                m_held = 1; m_ctrl = wb_ctrl; m_we = wb_ctrl[2]; m_dst = dst_reg;
                m_final = (wb_ctrl[1:0] != 2'b11);
                case (wb_ctrl[1:0])
                    2'b00:   m_val = alu_out;
                    2'b01:   m_val = pc_inc2;
                    2'b10:   m_val = ex_cond ? 16'd1 : 16'd0;
                    default: m_val = 16'h0;
                endcase
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_alu_stream();
        test_src_mux();
        test_late_load();
        test_byte_load();
        test_flush();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
